// File: rtl/ise_pkg.sv
// ise_pkg: shared types and helpers for the image sorting engine.
//   - colour class encodings (R, G, B, grey)
//   - sum_width(): per-channel accumulator width for a given channel width and image edge
//   - ise_rec_t: one record-memory entry {used, class, key, index}
//   - rec_less(): sort ordering, less-than on {class, ~key, index}
// Optional feature macro used by the engine: ISE_GREY_CLASS_EN.
package ise_pkg;

   typedef enum logic [1:0] {
      ClsR    = 2'd0,
      ClsG    = 2'd1,
      ClsB    = 2'd2,
      ClsGrey = 2'd3
   } ise_class_e;

   // Record fields are sized for the largest configuration (CH_W up to 32, 256x256
   // images, 64 images); narrower keys and indices are zero-extended.
   localparam int unsigned KeyMaxW = 48;
   localparam int unsigned IdxMaxW = 6;

   typedef struct packed {
      logic               used;
      ise_class_e         cls;
      logic [KeyMaxW-1:0] key;
      logic [IdxMaxW-1:0] idx;
   } ise_rec_t;

   function automatic int unsigned sum_width(input int unsigned ch_w, input int unsigned size);
      return ch_w + 2 * $clog2(size);
   endfunction

   // Class ascending, then key descending, then index ascending.
   function automatic logic rec_less(input ise_rec_t a, input ise_rec_t b);
      return {a.cls, ~a.key, a.idx} < {b.cls, ~b.key, b.idx};
   endfunction

endpackage

// File: rtl/ise_pixel_acc.sv
// ise_pixel_acc: pixel classifier and per-image accumulator.
// Two-stage pipeline: stage 1 classifies the accepted pixel, stage 2 updates the per-class
// counts and per-channel sums. After the last pixel of an image it issues a one-cycle
// record-write strobe carrying the finished record and its memory slot.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   accept_i           pixel accepted this cycle
//   idx_i, pixel_i     image index and {R,G,B} pixel
//   batch_last_o       accept of the final pixel of the batch (combinational)
//   wr_valid_o         record-write strobe; wr_slot_o / wr_rec_o carry slot and record
// ISE_GREY_CLASS_EN: when defined, R==G==B pixels form a fourth (grey) class.
module ise_pixel_acc
   import ise_pkg::*;
#(
   parameter int unsigned IMAGE_NUM  = 32,
   parameter int unsigned IMAGE_SIZE = 128,
   parameter int unsigned CH_W       = 8,
   parameter int unsigned IDX_W      = 5
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              accept_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [3*CH_W-1:0] pixel_i,
   output logic              batch_last_o,
   output logic              wr_valid_o,
   output logic [IDX_W-1:0]  wr_slot_o,
   output ise_rec_t          wr_rec_o
);

   localparam int unsigned PixW = 2 * $clog2(IMAGE_SIZE);
   localparam int unsigned SumW = sum_width(CH_W, IMAGE_SIZE);
   localparam int unsigned CntW = PixW + 1;
`ifdef ISE_GREY_CLASS_EN
   localparam int unsigned NCls = 4;
`else
   localparam int unsigned NCls = 3;
`endif
   localparam logic [IDX_W-1:0] LastImg = IDX_W'(IMAGE_NUM - 1);

   logic [PixW-1:0]  pix_cnt_q, pix_cnt_d;
   logic [IDX_W-1:0] img_cnt_q, img_cnt_d;
   logic             s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic [IDX_W-1:0] s1_slot_q, s1_slot_d, s1_idx_q, s1_idx_d;
   ise_class_e       s1_cls_q, s1_cls_d;
   logic [CH_W-1:0]  s1_ch_q [3];
   logic [CH_W-1:0]  s1_ch_d [3];
   logic [CntW-1:0]  cnt_q [NCls];
   logic [CntW-1:0]  cnt_d [NCls];
   logic [CntW-1:0]  cnt_new [NCls];
   logic [SumW-1:0]  sum_q [3];
   logic [SumW-1:0]  sum_d [3];
   logic [SumW-1:0]  sum_new [3];
   logic [IDX_W-1:0] rec_idx_q, rec_idx_d, rec_idx_new;
   logic             wr_valid_q, wr_valid_d;
   logic [IDX_W-1:0] wr_slot_q, wr_slot_d;
   ise_rec_t         wr_rec_q, wr_rec_d;

   logic [CH_W-1:0] r_in, g_in, b_in;
   ise_class_e      cls_in, win;
   logic [CntW-1:0] best_cnt;
   logic [SumW-1:0] key;
   logic            img_last;

   assign {r_in, g_in, b_in} = pixel_i;
   assign img_last           = &pix_cnt_q;
   assign batch_last_o       = accept_i && img_last && (img_cnt_q == LastImg);

   // Pixel class: largest channel, ties resolve R > G > B.
   always_comb begin
      cls_in = ClsR;
      if (r_in >= g_in && r_in >= b_in) begin
         cls_in = ClsR;
      end else if (g_in >= b_in) begin
         cls_in = ClsG;
      end else begin
         cls_in = ClsB;
      end
`ifdef ISE_GREY_CLASS_EN
      if (r_in == g_in && g_in == b_in) begin
         cls_in = ClsGrey;
      end
`endif
   end

   // Input counters and stage 1.
   always_comb begin
      pix_cnt_d  = pix_cnt_q;
      img_cnt_d  = img_cnt_q;
      if (accept_i) begin
         pix_cnt_d = pix_cnt_q + 1'b1;
         if (img_last) begin
            img_cnt_d = (img_cnt_q == LastImg) ? '0 : img_cnt_q + 1'b1;
         end
      end
      s1_valid_d = accept_i;
      s1_first_d = (pix_cnt_q == '0);
      s1_last_d  = img_last;
      s1_slot_d  = img_cnt_q;
      s1_idx_d   = idx_i;
      s1_cls_d   = cls_in;
      s1_ch_d[0] = r_in;
      s1_ch_d[1] = g_in;
      s1_ch_d[2] = b_in;
   end

   // Stage 2: the first pixel of an image restarts the accumulators.
   always_comb begin
      for (int c = 0; c < NCls; c++) begin
         cnt_new[c] = (s1_first_q ? '0 : cnt_q[c]) + CntW'(s1_cls_q == ise_class_e'(c));
      end
      for (int ch = 0; ch < 3; ch++) begin
         sum_new[ch] = (s1_first_q ? '0 : sum_q[ch]) + SumW'(s1_ch_q[ch]);
      end
      rec_idx_new = s1_first_q ? s1_idx_q : rec_idx_q;

      // Image class: highest count, ties resolve R > G > B > grey.
      win      = ClsR;
      best_cnt = cnt_new[0];
      if (cnt_new[1] > best_cnt) begin
         win      = ClsG;
         best_cnt = cnt_new[1];
      end
      if (cnt_new[2] > best_cnt) begin
         win      = ClsB;
         best_cnt = cnt_new[2];
      end
`ifdef ISE_GREY_CLASS_EN
      if (cnt_new[3] > best_cnt) begin
         win      = ClsGrey;
         best_cnt = cnt_new[3];
      end
`endif
      case (win)
         ClsG:    key = sum_new[1];
         ClsB:    key = sum_new[2];
         default: key = sum_new[0]; // R and grey
      endcase

      cnt_d     = cnt_q;
      sum_d     = sum_q;
      rec_idx_d = rec_idx_q;
      if (s1_valid_q) begin
         cnt_d     = cnt_new;
         sum_d     = sum_new;
         rec_idx_d = rec_idx_new;
      end
      wr_valid_d = s1_valid_q && s1_last_q;
      wr_slot_d  = s1_slot_q;
      wr_rec_d   = '{used: 1'b0, cls: win, key: KeyMaxW'(key), idx: IdxMaxW'(rec_idx_new)};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pix_cnt_q  <= '0;
         img_cnt_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_slot_q  <= '0;
         s1_idx_q   <= '0;
         s1_cls_q   <= ClsR;
         for (int ch = 0; ch < 3; ch++) begin
            s1_ch_q[ch] <= '0;
            sum_q[ch]   <= '0;
         end
         for (int c = 0; c < NCls; c++) begin
            cnt_q[c] <= '0;
         end
         rec_idx_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_slot_q  <= '0;
         wr_rec_q   <= '0;
      end else begin
         pix_cnt_q  <= pix_cnt_d;
         img_cnt_q  <= img_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         s1_slot_q  <= s1_slot_d;
         s1_idx_q   <= s1_idx_d;
         s1_cls_q   <= s1_cls_d;
         s1_ch_q    <= s1_ch_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         rec_idx_q  <= rec_idx_d;
         wr_valid_q <= wr_valid_d;
         wr_slot_q  <= wr_slot_d;
         wr_rec_q   <= wr_rec_d;
      end
   end

   assign wr_valid_o = wr_valid_q;
   assign wr_slot_o  = wr_slot_q;
   assign wr_rec_o   = wr_rec_q;

endmodule

// File: rtl/ise_sort_engine.sv
// ise_sort_engine: streams IMAGE_NUM square RGB images, classifies each by dominant colour
// and emits the image indices sorted by class, then channel-sum key, then index.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid            pixel strobe, accepted when in_valid && !busy
//   image_in_index      image index of the pixel
//   pixel_in            {R,G,B}, R in the MSBs
//   busy                input not accepted (FLUSH/SCAN/EMIT)
//   out_valid           one-cycle pulse per sorted result
//   color_index         class of the emitted image (0=R 1=G 2=B 3=grey)
//   image_out_index     index of the emitted image
// ISE_GREY_CLASS_EN: define to enable the grey class (passed to ise_pixel_acc).
module ise_sort_engine
   import ise_pkg::*;
#(
   parameter int unsigned IMAGE_NUM  = 32,
   parameter int unsigned IMAGE_SIZE = 128,
   parameter int unsigned CH_W       = 8,
   localparam int unsigned IDX_W     = (IMAGE_NUM > 1) ? $clog2(IMAGE_NUM) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [IDX_W-1:0]  image_in_index,
   input  logic [3*CH_W-1:0] pixel_in,
   output logic              busy,
   output logic              out_valid,
   output logic [1:0]        color_index,
   output logic [IDX_W-1:0]  image_out_index
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(IMAGE_NUM - 1);

   typedef enum logic [1:0] {StIdle, StFlush, StScan, StEmit} state_e;

   state_e           state_q, state_d;
   logic             flush_q, flush_d;
   logic [IDX_W-1:0] scan_q, scan_d, emit_q, emit_d, best_ptr_q, best_ptr_d;
   logic             best_valid_q, best_valid_d;
   ise_rec_t         mem_q [IMAGE_NUM];
   ise_rec_t         mem_d [IMAGE_NUM];
   logic             busy_q, busy_d, out_valid_q, out_valid_d;
   logic [1:0]       color_q, color_d;
   logic [IDX_W-1:0] img_out_q, img_out_d;

   logic             accept, batch_last, wr_valid;
   logic [IDX_W-1:0] wr_slot;
   ise_rec_t         wr_rec, cand, cur;

   assign accept = in_valid && !busy_q;
   assign cand   = mem_q[scan_q];
   assign cur    = mem_q[best_ptr_q];

   ise_pixel_acc #(
      .IMAGE_NUM  (IMAGE_NUM),
      .IMAGE_SIZE (IMAGE_SIZE),
      .CH_W       (CH_W),
      .IDX_W      (IDX_W)
   ) u_acc (
      .clk_i        (clk),
      .reset_i      (reset),
      .accept_i     (accept),
      .idx_i        (image_in_index),
      .pixel_i      (pixel_in),
      .batch_last_o (batch_last),
      .wr_valid_o   (wr_valid),
      .wr_slot_o    (wr_slot),
      .wr_rec_o     (wr_rec)
   );

   always_comb begin
      state_d      = state_q;
      flush_d      = flush_q;
      scan_d       = scan_q;
      emit_d       = emit_q;
      best_ptr_d   = best_ptr_q;
      best_valid_d = best_valid_q;
      mem_d        = mem_q;
      out_valid_d  = 1'b0;
      color_d      = color_q;
      img_out_d    = img_out_q;

      if (wr_valid) begin
         mem_d[wr_slot] = wr_rec;
      end

      unique case (state_q)
         StIdle: begin
            flush_d = 1'b0;
            if (batch_last) begin
               state_d = StFlush;
            end
         end
         // Two cycles let the last pixel clear the pipeline and its record land in memory.
         StFlush: begin
            flush_d = 1'b1;
            if (flush_q) begin
               state_d      = StScan;
               scan_d       = '0;
               best_valid_d = 1'b0;
            end
         end
         StScan: begin
            if (!cand.used && (!best_valid_q || rec_less(cand, cur))) begin
               best_valid_d = 1'b1;
               best_ptr_d   = scan_q;
            end
            if (scan_q == LastIdx) begin
               state_d = StEmit;
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end
         StEmit: begin
            mem_d[best_ptr_q].used = 1'b1;
            out_valid_d            = 1'b1;
            color_d                = cur.cls;
            img_out_d              = cur.idx[IDX_W-1:0];
            scan_d                 = '0;
            best_valid_d           = 1'b0;
            if (emit_q == LastIdx) begin
               state_d = StIdle;
               emit_d  = '0;
            end else begin
               state_d = StScan;
               emit_d  = emit_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         flush_q      <= 1'b0;
         scan_q       <= '0;
         emit_q       <= '0;
         best_ptr_q   <= '0;
         best_valid_q <= 1'b0;
         for (int i = 0; i < IMAGE_NUM; i++) begin
            mem_q[i] <= '0;
         end
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         color_q      <= '0;
         img_out_q    <= '0;
      end else begin
         state_q      <= state_d;
         flush_q      <= flush_d;
         scan_q       <= scan_d;
         emit_q       <= emit_d;
         best_ptr_q   <= best_ptr_d;
         best_valid_q <= best_valid_d;
         mem_q        <= mem_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         color_q      <= color_d;
         img_out_q    <= img_out_d;
      end
   end

   assign busy            = busy_q;
   assign out_valid       = out_valid_q;
   assign color_index     = color_q;
   assign image_out_index = img_out_q;

endmodule

// File: tb/tb_ise_sort_engine.sv
// Directed bench for ise_sort_engine with IMAGE_NUM=4, IMAGE_SIZE=2, CH_W=8.
// Expected {class, index} pairs go into a queue as each batch is driven; a negedge monitor
// pops and compares them on every out_valid pulse, along with the pulse timing.
module tb_ise_sort_engine;

   localparam int unsigned N  = 4;
   localparam int unsigned SZ = 2;
   localparam int unsigned CW = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [1:0]  image_in_index = '0;
   logic [23:0] pixel_in = '0;
   logic        busy, out_valid;
   logic [1:0]  color_index;
   logic [1:0]  image_out_index;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          pulses = 0;
   int          exp_cyc = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  e;

`ifdef ISE_GREY_CLASS_EN
   localparam logic [1:0] GreyCls = 2'd3;
`else
   localparam logic [1:0] GreyCls = 2'd0;
`endif

   ise_sort_engine #(
      .IMAGE_NUM  (N),
      .IMAGE_SIZE (SZ),
      .CH_W       (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .image_in_index  (image_in_index),
      .pixel_in        (pixel_in),
      .busy            (busy),
      .out_valid       (out_valid),
      .color_index     (color_index),
      .image_out_index (image_out_index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("color_index", 32'(color_index), 32'(e[3:2]));
            chk("image_out_index", 32'(image_out_index), 32'(e[1:0]));
            chk("pulse_cycle", cyc, exp_cyc);
            exp_cyc = exp_cyc + N + 1;
            if (exp_q.size() == 0) chk("busy_after_final", 32'(busy), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0][23:0] all4(input logic [23:0] p);
      return {p, p, p, p};
   endfunction

   // gap: idle garbage cycle before each pixel; scramble: non-first pixels carry a wrong index.
   task automatic send_img(input logic [1:0] idx, input logic [3:0][23:0] px, input bit gap,
                           input bit scramble);
      for (int p = 0; p < 4; p++) begin
         if (gap) begin
            in_valid       = 1'b0;
            pixel_in       = 24'hFFFFFF;
            image_in_index = ~idx;
            tick();
         end
         in_valid       = 1'b1;
         pixel_in       = px[p];
         image_in_index = (scramble && p != 0) ? ~idx : idx;
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Called right after the final pixel edge of a batch.
   task automatic batch_done(input bit garbage);
      exp_cyc = cyc + N + 3;
      chk("busy_after_last_pixel", 32'(busy), 32'd1);
      if (garbage) begin
         // Pixels offered while busy must be ignored.
         in_valid = 1'b1;
         pixel_in = 24'h0000FF;
         for (int i = 0; i < 3; i++) tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   task automatic batch_a(input bit gap, input bit garbage);
      exp_q.push_back({2'd0, 2'd2});
      exp_q.push_back({2'd0, 2'd0});
      exp_q.push_back({2'd1, 2'd1});
      exp_q.push_back({2'd2, 2'd3});
      send_img(2'd0, all4(24'h100000), gap, 1'b0);
      send_img(2'd1, all4(24'h002000), gap, 1'b0);
      send_img(2'd2, all4(24'h400000), gap, 1'b0);
      chk("busy_during_load", 32'(busy), 32'd0);
      send_img(2'd3, all4(24'h000005), gap, 1'b0);
      batch_done(garbage);
   endtask

   initial begin
      int start;
      // Reset state.
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_color_index", 32'(color_index), 32'd0);
      chk("rst_image_out_index", 32'(image_out_index), 32'd0);
      reset = 1'b0;
      tick();

      // Basic batch, garbage offered while busy.
      batch_a(1'b0, 1'b1);
      wait_drain("batch_a");

      // Same images with in_valid toggling.
      batch_a(1'b1, 1'b0);
      wait_drain("batch_a_gap");

      // All pixels 0x808080: grey class when enabled, otherwise R by tie priority.
      for (int i = 0; i < 4; i++) exp_q.push_back({GreyCls, 2'(i)});
      for (int i = 0; i < 4; i++) send_img(2'(i), all4(24'h808080), 1'b0, 1'b0);
      batch_done(1'b0);
      wait_drain("grey");

      // Equal R keys sent out of index order; index taken from each image's first pixel.
      for (int i = 0; i < 4; i++) exp_q.push_back({2'd0, 2'(i)});
      send_img(2'd3, all4(24'h300000), 1'b0, 1'b1);
      send_img(2'd1, all4(24'h300000), 1'b0, 1'b1);
      send_img(2'd2, all4(24'h300000), 1'b0, 1'b1);
      send_img(2'd0, all4(24'h300000), 1'b0, 1'b1);
      batch_done(1'b0);
      wait_drain("equal_key");

      // Mixed images: count ties and channel ties resolve toward R.
      exp_q.push_back({2'd0, 2'd3});
      exp_q.push_back({2'd0, 2'd0});
      exp_q.push_back({2'd1, 2'd1});
      exp_q.push_back({2'd2, 2'd2});
      send_img(2'd0, {24'h500000, 24'h500000, 24'h006000, 24'h006000}, 1'b0, 1'b0);
      send_img(2'd1, all4(24'h001000), 1'b0, 1'b0);
      send_img(2'd2, {24'h700000, 24'h007000, 24'h000011, 24'h000022}, 1'b0, 1'b0);
      send_img(2'd3, all4(24'h303010), 1'b0, 1'b0);
      batch_done(1'b0);
      wait_drain("mixed");

      // Reset during the second SCAN aborts the batch.
      batch_a(1'b0, 1'b0);
      start = pulses;
      for (int n = 0; n < 100 && pulses == start; n++) tick();
      chk("first_pulse_seen", pulses - start, 1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      start = pulses;
      for (int n = 0; n < 30; n++) tick();
      chk("no_pulse_after_abort", pulses - start, 0);

      // Fresh batch after abort.
      batch_a(1'b0, 1'b0);
      wait_drain("after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
